// File: rtl/display_pkg.sv
// display_pkg: shared constants and types for the BCD display driver.
//   SEG_BLANK / SEG_DASH : active-low 7-segment patterns (bit order gfedcba)
//   state_t              : conversion FSM states
//   cnt_width()          : bit-counter width needed to count WIDTH shifts
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  // Counter width for the default 32-bit configuration; parameterised
  // instances size their counter with cnt_width().
  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned CNT_W         = $clog2(DEFAULT_WIDTH + 1);

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bcd_display_driver_dd_step.sv
// dd_step: one double-dabble iteration over DIGITS BCD digits.
//   i_bcd   : current scratch BCD digits, digit 0 in [3:0]
//   i_bit   : next binary bit shifted in at the bottom
//   o_bcd   : digits after add-3 correction and a 1-bit left shift
//   o_carry : bit shifted out of the top digit's MSB
module dd_step #(
  parameter int DIGITS = 5
) (
  input  logic [4*DIGITS-1:0] i_bcd,
  input  logic                i_bit,
  output logic [4*DIGITS-1:0] o_bcd,
  output logic                o_carry
);

  logic [4*DIGITS-1:0] w_adj;

  // A digit >= 5 would become >= 10 after doubling; adding 3 first makes the
  // shift carry the excess into the next digit.
  always_comb begin
    w_adj = i_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (i_bcd[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = i_bcd[4*d +: 4] + 4'd3;
      end
    end
  end

  assign {o_carry, o_bcd} = {w_adj, i_bit};

endmodule

// File: rtl/seg7.sv
// seg7: nibble to 7-segment decoder, active-low, bit order gfedcba.
//   i_nibble : 4-bit value 0..F
//   o_seg    : segment pattern (0 -> 7'b1000000)
module seg7 (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'b1111111;
    case (i_nibble)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      4'hF: o_seg = 7'b0001110;
      default: o_seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/bcd_display_driver.sv
// bcd_display_driver: iterative binary-to-BCD converter with 7-segment drive.
//   clk, rst   : clock, synchronous active-high reset
//   value      : unsigned number, sampled with hex_mode when load is accepted
//   load       : request pulse, accepted only in IDLE (dropped while busy)
//   hex_mode   : 1 = hex nibbles, 0 = decimal
//   busy       : conversion in progress
//   done       : one-cycle pulse when bcd/overflow/seg have been updated
//   overflow   : value does not fit in DIGITS digits
//   bcd        : digit nibbles, digit 0 in [3:0]
//   seg        : active-low segments, digit i in [7i+6:7i], gfedcba
//   dbg_state  : current FSM state, for observation only
// Handshake: load is a request without backpressure; it is taken on any
// clock edge where the FSM is IDLE (including the cycle done is high) and
// ignored otherwise. done marks the single cycle in which new results
// first appear; outputs then hold until the next done.
module bcd_display_driver
  import display_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int DIGITS        = 5,
  parameter int BLANK_LEADING = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    value,
  input  logic                load,
  input  logic                hex_mode,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [4*DIGITS-1:0] bcd,
  output logic [7*DIGITS-1:0] seg,
  output logic [1:0]          dbg_state
);

  localparam int CW = cnt_width(WIDTH);

  state_t              r_state;
  state_t              w_next;
  logic [WIDTH-1:0]    r_shift;
  logic [4*DIGITS-1:0] r_scratch;
  logic                r_sticky;
  logic                r_mode;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_ovf;
  logic [4*DIGITS-1:0] r_bcd;
  logic [7*DIGITS-1:0] r_seg;

  logic [4*DIGITS-1:0] w_step_bcd;
  logic                w_step_carry;
  logic                w_last_bit;

  dd_step #(.DIGITS(DIGITS)) u_dd_step (
    .i_bcd   (r_scratch),
    .i_bit   (r_shift[WIDTH-1]),
    .o_bcd   (w_step_bcd),
    .o_carry (w_step_carry)
  );

  assign w_last_bit = (r_cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (load) w_next = hex_mode ? UPDATE : SHIFT;
      SHIFT:   if (w_last_bit) w_next = UPDATE;
      UPDATE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Result selection. Hex mode never shifts, so r_shift still holds the
  // captured value; zero-extension covers WIDTH < 4*DIGITS.
  logic [4*DIGITS+WIDTH-1:0] w_ext;
  logic [4*DIGITS-1:0]       w_res_bcd;
  logic                      w_res_ovf;
  logic [7*DIGITS-1:0]       w_dec_seg;
  logic [7*DIGITS-1:0]       w_res_seg;
  logic [DIGITS-1:0]         w_lz;

  assign w_ext     = {{(4*DIGITS){1'b0}}, r_shift};
  assign w_res_bcd = r_mode ? w_ext[4*DIGITS-1:0] : r_scratch;
  assign w_res_ovf = r_mode ? (|w_ext[4*DIGITS+WIDTH-1:4*DIGITS]) : r_sticky;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    seg7 u_seg7 (
      .i_nibble (w_res_bcd[4*gi +: 4]),
      .o_seg    (w_dec_seg[7*gi +: 7])
    );
  end

  // w_lz[i]: digit i and every digit above it are zero.
  always_comb begin
    w_lz = '0;
    w_lz[DIGITS-1] = (w_res_bcd[4*(DIGITS-1) +: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      w_lz[i] = w_lz[i+1] && (w_res_bcd[4*i +: 4] == 4'd0);
    end
  end

  // Dash beats blanking; digit 0 is never blanked so zero shows as "0".
  always_comb begin
    w_res_seg = w_dec_seg;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_res_ovf) begin
        w_res_seg[7*i +: 7] = SEG_DASH;
      end else if ((BLANK_LEADING != 0) && (i > 0) && w_lz[i]) begin
        w_res_seg[7*i +: 7] = SEG_BLANK;
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_scratch <= '0;
      r_sticky  <= 1'b0;
      r_mode    <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
      r_bcd     <= '0;
      r_seg     <= {DIGITS{SEG_BLANK}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load) begin
            r_shift   <= value;
            r_mode    <= hex_mode;
            r_scratch <= '0;
            r_sticky  <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
          end
        end
        SHIFT: begin
          r_scratch <= w_step_bcd;
          r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
          r_sticky  <= r_sticky | w_step_carry;
          r_cnt     <= r_cnt + CW'(1);
        end
        UPDATE: begin
          r_bcd  <= w_res_bcd;
          r_ovf  <= w_res_ovf;
          r_seg  <= w_res_seg;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign overflow  = r_ovf;
  assign bcd       = r_bcd;
  assign seg       = r_seg;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Testbench for bcd_display_driver: directed vector table, randomized
// checks against an arithmetic reference model, and hand-written sequences
// for dropped loads and reset during a conversion.
module tb_bcd_display_driver;

  localparam int W = 32;
  localparam int D = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   value;
  logic           load;
  logic           hex_mode;
  logic           busy;
  logic           done;
  logic           overflow;
  logic [4*D-1:0] bcd;
  logic [7*D-1:0] seg;
  logic [1:0]     dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Clock / reset
  always #5 clk = ~clk;

  bcd_display_driver #(.WIDTH(W), .DIGITS(D), .BLANK_LEADING(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .load      (load),
    .hex_mode  (hex_mode),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .bcd       (bcd),
    .seg       (seg),
    .dbg_state (dbg_state)
  );

  // Scoreboard compare
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain base-10 / base-16 arithmetic on the value.
  task automatic model(input logic [W-1:0] v, input logic h,
                       output logic [4*D-1:0] eb, output logic eo,
                       output logic [7*D-1:0] es);
    longint unsigned x, lim, rem, base;
    int dig [D];
    int top;
    x    = {32'b0, v};
    base = h ? 64'd16 : 64'd10;
    lim  = 1;
    for (int i = 0; i < D; i++) lim = lim * base;
    eo  = (x >= lim);
    rem = x % lim;
    top = 0;
    for (int i = 0; i < D; i++) begin
      dig[i] = int'(rem % base);
      rem    = rem / base;
      if (dig[i] != 0) top = i;
    end
    eb = '0;
    es = '0;
    for (int i = 0; i < D; i++) begin
      eb[4*i +: 4] = 4'(dig[i]);
      if (eo)           es[7*i +: 7] = 7'b0111111;
      else if (i > top) es[7*i +: 7] = 7'b1111111;
      else              es[7*i +: 7] = seg_tab[dig[i]];
    end
  endtask

  // Driver: entered at a falling edge; returns at the falling edge where
  // done is seen, with lat = rising edges after the accepting edge.
  task automatic convert(input logic [W-1:0] v, input logic h, output int lat);
    value    = v;
    hex_mode = h;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    lat  = 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [W-1:0]   val;
    logic           hex;
    logic [4*D-1:0] e_bcd;
    logic           e_ovf;
    logic [7*D-1:0] e_seg;
    int             e_lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int             lat;
    int             n_done;
    logic [4*D-1:0] mb;
    logic           mo;
    logic [7*D-1:0] ms;
    logic [W-1:0]   rv;
    logic           rh;

    vecs[0] = '{32'd12345, 1'b0, 20'h12345, 1'b0,
                {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010}, 33};
    vecs[1] = '{32'd7, 1'b0, 20'h00007, 1'b0,
                {{4{7'b1111111}}, 7'b1111000}, 33};
    vecs[2] = '{32'd0, 1'b0, 20'h00000, 1'b0,
                {{4{7'b1111111}}, 7'b1000000}, 33};
    vecs[3] = '{32'd100000, 1'b0, 20'h00000, 1'b1, {5{7'b0111111}}, 33};
    vecs[4] = '{32'd99999, 1'b0, 20'h99999, 1'b0, {5{7'b0010000}}, 33};
    vecs[5] = '{32'h000ABCDE, 1'b1, 20'hABCDE, 1'b0,
                {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110}, 1};
    vecs[6] = '{32'h00100000, 1'b1, 20'h00000, 1'b1, {5{7'b0111111}}, 1};
    vecs[7] = '{32'h0000000F, 1'b1, 20'h0000F, 1'b0,
                {{4{7'b1111111}}, 7'b0001110}, 1};

    rst = 1'b1; load = 1'b0; hex_mode = 1'b0; value = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_bcd", bcd, 0);
    chk("rst_seg", seg, {D{7'b1111111}});
    chk("rst_state", dbg_state, 0);

    // Directed table
    foreach (vecs[k]) begin
      convert(vecs[k].val, vecs[k].hex, lat);
      chk($sformatf("vec%0d_lat", k), lat, vecs[k].e_lat);
      chk($sformatf("vec%0d_bcd", k), bcd, vecs[k].e_bcd);
      chk($sformatf("vec%0d_ovf", k), overflow, vecs[k].e_ovf);
      chk($sformatf("vec%0d_seg", k), seg, vecs[k].e_seg);
      chk($sformatf("vec%0d_busy", k), busy, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_pulse", k), done, 0);
      chk($sformatf("vec%0d_hold", k), bcd, vecs[k].e_bcd);
    end

    // Randomized against the model
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       begin rv = $urandom_range(0, 99999);   rh = 1'b0; end
        1:       begin rv = $urandom;                   rh = 1'b0; end
        2:       begin rv = $urandom_range(0, 1200000); rh = 1'b1; end
        default: begin rv = $urandom_range(0, 999);     rh = 1'($urandom_range(0, 1)); end
      endcase
      model(rv, rh, mb, mo, ms);
      convert(rv, rh, lat);
      chk($sformatf("rnd%0d_lat v=%0h", n, rv), lat, rh ? 1 : 33);
      chk($sformatf("rnd%0d_bcd v=%0h", n, rv), bcd, mb);
      chk($sformatf("rnd%0d_ovf v=%0h", n, rv), overflow, mo);
      chk($sformatf("rnd%0d_seg v=%0h", n, rv), seg, ms);
    end

    // Load while busy is dropped; load in the done cycle is taken.
    @(negedge clk);
    value = 32'd42; hex_mode = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    lat  = 0;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 5) begin
        chk("drop_busy_mid", busy, 1);
        value = 32'd99;
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
    chk("drop_lat", lat, 33);
    chk("drop_bcd", bcd, 20'h00042);
    convert(32'd99, 1'b0, lat);
    chk("donecyc_lat", lat, 33);
    chk("donecyc_bcd", bcd, 20'h00099);
    chk("donecyc_seg", seg, {{3{7'b1111111}}, 7'b0010000, 7'b0010000});

    // Reset in the middle of a conversion
    @(negedge clk);
    value = 32'd12345; hex_mode = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ovf", overflow, 0);
    chk("midrst_bcd", bcd, 0);
    chk("midrst_seg", seg, {D{7'b1111111}});
    chk("midrst_state", dbg_state, 0);
    rst    = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("midrst_no_done", n_done, 0);
    chk("midrst_bcd_hold", bcd, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
